fx_master: RTL and testbench

//  Initiator end of the fx register bus; every register block (e.g. dsp_regs) is a responder on it.

---
 rtl/fx_master_pkg.sv | 19 +
 rtl/fx_frame_tmr.sv | 27 ++
 rtl/fx_master.sv | 160 ++++++++++++++++
 tb/tb_fx_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_master_pkg.sv
// Shared fx bus definitions: bus widths, default opcodes and the master FSM states.
package fx_master_pkg;

  localparam int unsigned FX_AW     = 22;
  localparam int unsigned FX_DW     = 8;
  localparam logic [7:0]  OP_WR_DEF = 8'h57;
  localparam logic [7:0]  OP_RD_DEF = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WR,
    ST_RD,
    ST_RWAIT,
    ST_RSP
  } fx_state_e;

endpackage

// File: rtl/fx_frame_tmr.sv
// Inter-byte frame timeout: counts enabled idle cycles, pulses expire_o on the TMO-th one.
module fx_frame_tmr #(
  parameter logic [15:0] TMO = 16'hFFFF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr_i || !en_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // An accepted byte in the same cycle always wins over expiry.
  assign expire_o = en_i && !clr_i && (cnt_q == TMO - 16'd1);

endmodule

// File: rtl/fx_master.sv
// fx bus initiator: parses host byte frames (op, A2, A1, A0[, D]) into fx_wr / fx_rd
// transactions and returns one response byte per read.
module fx_master
  import fx_master_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter logic [15:0] TMO    = 16'hFFFF,
  parameter logic [7:0]  OP_WR  = OP_WR_DEF,
  parameter logic [7:0]  OP_RD  = OP_RD_DEF
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  output logic [7:0]        rsp_data,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [FX_AW-1:0]  fx_waddr,
  output logic [FX_DW-1:0]  fx_data,
  output logic              fx_wr,
  output logic [FX_AW-1:0]  fx_raddr,
  output logic              fx_rd,
  input  logic [FX_DW-1:0]  fx_q,
  output logic              busy,
  output logic              err_op
);

  fx_state_e        state_q, state_d;
  logic             is_rd_q, is_rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [FX_AW-1:0] addr_q, addr_d, addr_sh;
  logic [FX_AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [7:0]       data_q, data_d, rsp_q, rsp_d;
  logic             err_q, err_d;
  logic [3:0]       lat_q, lat_d;
  logic             in_frame, accept, expire;

  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign cmd_rdy  = !rst && ((state_q == ST_IDLE) || in_frame);
  assign accept   = cmd_vld && cmd_rdy;
  // 24-bit address shifted in MSB first; the two top bits fall off the 22-bit register.
  assign addr_sh  = {addr_q[FX_AW-9:0], cmd_data};

  fx_frame_tmr #(.TMO(TMO)) u_tmr (
    .clk_i    (clk_sys),
    .rst_i    (rst),
    .clr_i    (accept),
    .en_i     (in_frame),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    err_d   = 1'b0;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (cmd_data == OP_WR) begin
            state_d = ST_ADDR;
            is_rd_d = 1'b0;
          end else if (cmd_data == OP_RD) begin
            state_d = ST_ADDR;
            is_rd_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (accept) begin
          addr_d = addr_sh;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            if (is_rd_q) begin
              state_d = ST_RD;
              raddr_d = addr_sh;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (accept) begin
          state_d = ST_WR;
          waddr_d = addr_q;
          data_d  = cmd_data;
        end
      end
      ST_WR:   state_d = ST_IDLE;
      ST_RD: begin
        state_d = ST_RWAIT;
        lat_d   = 4'd1;
      end
      ST_RWAIT: begin
        if (lat_q == 4'(RD_LAT)) begin
          state_d = ST_RSP;
          rsp_d   = fx_q;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      ST_RSP:  if (rsp_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= ST_IDLE;
      is_rd_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
    end
  end

  assign fx_wr    = (state_q == ST_WR);
  assign fx_rd    = (state_q == ST_RD);
  assign rsp_vld  = (state_q == ST_RSP);
  assign busy     = (state_q != ST_IDLE);
  assign err_op   = err_q;
  assign fx_waddr = waddr_q;
  assign fx_raddr = raddr_q;
  assign fx_data  = data_q;
  assign rsp_data = rsp_q;

endmodule

// File: tb/tb_fx_master.sv
// Self-checking bench for fx_master: directed frames plus randomized write/read traffic
// checked against an address-keyed memory model and a latency-accurate responder.
module tb_fx_master;

  localparam int unsigned RD_LAT = 2;
  localparam logic [15:0] TMO    = 16'd16;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [7:0]  cmd_data;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [7:0]  rsp_data;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_wr;
  logic [21:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q;
  logic        busy;
  logic        err_op;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0;

  logic [7:0]  exp_mem  [logic [21:0]];
  logic [7:0]  resp_mem [logic [21:0]];
  int unsigned due_q [$];
  logic [7:0]  dat_q [$];

  fx_master #(.RD_LAT(RD_LAT), .TMO(TMO), .OP_WR(8'h57), .OP_RD(8'h52)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .cmd_data (cmd_data),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .rsp_data (rsp_data),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .fx_waddr (fx_waddr),
    .fx_data  (fx_data),
    .fx_wr    (fx_wr),
    .fx_raddr (fx_raddr),
    .fx_rd    (fx_rd),
    .fx_q     (fx_q),
    .busy     (busy),
    .err_op   (err_op)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] dflt(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // Bus activity observed in the cycle that ends at this edge.
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (fx_wr) wr_cnt <= wr_cnt + 1;
      if (fx_rd) rd_cnt <= rd_cnt + 1;
      if (err_op) err_cnt <= err_cnt + 1;
      if (fx_wr && fx_rd) both_cnt <= both_cnt + 1;
    end
  end

  // Responder: fx_q carries the read data exactly RD_LAT cycles after fx_rd, noise otherwise.
  always @(negedge clk_sys) begin
    if (fx_wr) resp_mem[fx_waddr] = fx_data;
    if (fx_rd) begin
      due_q.push_back(cyc + RD_LAT);
      dat_q.push_back(resp_mem.exists(fx_raddr) ? resp_mem[fx_raddr] : dflt(fx_raddr));
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      fx_q = dat_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      fx_q = 8'($urandom);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    cmd_data = b;
    cmd_vld  = 1'b1;
    while (cmd_rdy !== 1'b1 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) chk("send_wait", 32'(cmd_rdy), 32'd1);
    @(negedge clk_sys);
  endtask

  task automatic idle();
    cmd_vld  = 1'b0;
    cmd_data = 8'($urandom);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] d, input string tag);
    int unsigned w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(d);
    idle();
    chk({tag, "_wr"}, 32'(fx_wr), 32'd1);
    chk({tag, "_waddr"}, 32'(fx_waddr), 32'(a[21:0]));
    chk({tag, "_wdata"}, 32'(fx_data), 32'(d));
    chk({tag, "_rdy_in_wr"}, 32'(cmd_rdy), 32'd0);
    @(negedge clk_sys);
    chk({tag, "_wr_end"}, 32'(fx_wr), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_wr_count"}, wr_cnt - w0, 32'd1);
    exp_mem[a[21:0]] = d;
  endtask

  task automatic do_read(input logic [23:0] a, input int unsigned hold, input string tag);
    int unsigned n = 0;
    logic [7:0]  e;
    e = exp_mem.exists(a[21:0]) ? exp_mem[a[21:0]] : dflt(a[21:0]);
    rsp_rdy = 1'b0;
    send_byte(8'h52);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    idle();
    chk({tag, "_rd"}, 32'(fx_rd), 32'd1);
    chk({tag, "_raddr"}, 32'(fx_raddr), 32'(a[21:0]));
    while (rsp_vld !== 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_rsp_latency"}, n, RD_LAT + 1);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(e));
    repeat (hold) @(negedge clk_sys);
    chk({tag, "_rsp_held"}, 32'(rsp_vld), 32'd1);
    chk({tag, "_rsp_data_held"}, 32'(rsp_data), 32'(e));
    rsp_rdy = 1'b1;
    @(negedge clk_sys);
    rsp_rdy = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(rsp_vld), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned k, r0, exp_err;
    logic [7:0]  b;
    logic [7:0]  stream [10];
    logic [23:0] a;
    logic [23:0] pool [4];

    rst = 1'b1;
    cmd_vld = 1'b0;
    cmd_data = 8'h00;
    rsp_rdy = 1'b0;
    exp_err = 0;
    repeat (3) @(negedge clk_sys);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_fx_wr", 32'(fx_wr), 32'd0);
    chk("rst_fx_rd", 32'(fx_rd), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_err_op", 32'(err_op), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr_data", {2'b0, fx_waddr, fx_data}, 32'd0);
    chk("rst_raddr_rsp", {2'b0, fx_raddr, rsp_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("idle_cmd_rdy", 32'(cmd_rdy), 32'd1);

    do_write(24'h000123, 8'hA5, "t1");
    do_read(24'h3FFFFF, 10, "t2");

    // Bad opcode followed by a normal write.
    b = 8'($urandom);
    if (b == 8'h57 || b == 8'h52) b = 8'h00;
    send_byte(b);
    idle();
    chk("bad_err_pulse", 32'(err_op), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    @(negedge clk_sys);
    chk("bad_err_end", 32'(err_op), 32'd0);
    exp_err++;
    do_write(24'hC12345, 8'h3C, "t3");

    // Frame timeout after 57 00 then silence.
    r0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h00);
    idle();
    k = 0;
    while (err_op !== 1'b1 && k < 60) begin
      @(negedge clk_sys);
      k++;
    end
    chk("tmo_delay", k, 32'(TMO));
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_no_wr", wr_cnt - r0, 32'd0);
    exp_err++;
    @(negedge clk_sys);

    // Reset after A1 of a read discards the frame.
    r0 = rd_cnt;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h01);
    idle();
    rst = 1'b1;
    @(negedge clk_sys);
    chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk_sys);
    chk("midrst_no_rd", rd_cnt - r0, 32'd0);
    chk("midrst_rsp_vld", 32'(rsp_vld), 32'd0);
    do_read(24'h000123, 2, "t5");

    // Two writes streamed with cmd_vld held high throughout.
    stream = '{8'h57, 8'h00, 8'h10, 8'h20, 8'h11, 8'h57, 8'h01, 8'h30, 8'h40, 8'h22};
    r0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      send_byte(stream[i]);
      if (i == 4 || i == 9) begin
        chk("b2b_wr", 32'(fx_wr), 32'd1);
        chk("b2b_rdy_low", 32'(cmd_rdy), 32'd0);
        chk("b2b_waddr", 32'(fx_waddr), (i == 4) ? 32'h1020 : 32'h13040);
        chk("b2b_wdata", 32'(fx_data), (i == 4) ? 32'h11 : 32'h22);
      end
    end
    idle();
    @(negedge clk_sys);
    chk("b2b_wr_count", wr_cnt - r0, 32'd2);
    exp_mem[22'h001020] = 8'h11;
    exp_mem[22'h013040] = 8'h22;

    // Randomized traffic over a small address pool so reads hit earlier writes.
    for (int i = 0; i < 4; i++) pool[i] = 24'($urandom);
    for (int i = 0; i < 24; i++) begin
      a = pool[$urandom_range(0, 3)];
      a[23:22] = 2'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(a, 8'($urandom), "rnd");
      else                            do_read(a, $urandom_range(0, 4), "rnd");
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) @(negedge clk_sys);
    end

    chk("never_wr_and_rd", both_cnt, 32'd0);
    chk("err_pulse_total", err_cnt, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
